// File: rtl/adder_stream_sequencer.sv
// adder_stream_sequencer
// Registered front-end and back-end around an external combinational 8-bit
// prefix adder. Operand pairs arrive over a valid/ready stream and wait in a
// small FIFO. The issue stage drives the adder inputs from registers. The
// result stage captures the adder sum one cycle later.
// An accumulate mode replaces operand B with the previous result. Before the
// adder can use that result, it must have been captured, so a dependent op
// waits one bubble cycle behind the op it depends on.
// Optional build macro: ADDER_STREAM_CHECK_EN adds a sticky chk_err output.
// That output flags any captured sum that differs from adder_a + adder_b.
`timescale 1ns/1ps

module adder_stream_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_acc,
    input  logic                     in_clr,
    output logic [WIDTH-1:0]         adder_a,
    output logic [WIDTH-1:0]         adder_b,
    input  logic [WIDTH-1:0]         adder_sum,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic [$clog2(DEPTH):0]   fifo_level,
`ifdef ADDER_STREAM_CHECK_EN
    output logic                     chk_err,
`endif
    output logic [CNT_W-1:0]         op_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_a   [DEPTH];
    logic [WIDTH-1:0] mem_b   [DEPTH];
    logic             mem_acc [DEPTH];
    logic             mem_clr [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             iss_vld;
    logic [WIDTH-1:0] acc;

    logic             fifo_empty;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             res_free;
    logic             capture;
    logic             advance;
    logic             hazard;
    logic             load;
    logic [WIDTH-1:0] head_a;
    logic [WIDTH-1:0] head_b;
    logic             head_acc;
    logic             head_clr;
    logic [WIDTH-1:0] next_b;

    // Handshake and pipeline control. A dependent accumulate op is held while the
    // issue stage still owns the op that produces its B operand.
    always_comb begin
        fifo_empty = (fifo_level == '0);
        fifo_full  = (fifo_level == LW'(DEPTH));
        in_ready   = !fifo_full;
        push       = in_valid && !fifo_full;
        head_a     = mem_a[rd_ptr];
        head_b     = mem_b[rd_ptr];
        head_acc   = mem_acc[rd_ptr];
        head_clr   = mem_clr[rd_ptr];
        res_free   = !out_valid || out_ready;
        capture    = iss_vld && res_free;
        advance    = !iss_vld || res_free;
        hazard     = head_acc && iss_vld;
        load       = !fifo_empty && advance && !hazard;
        pop        = load;
        next_b     = head_b;
        if (head_acc) begin
            next_b = head_clr ? '0 : acc;
        end
    end

    // FIFO storage. This array holds data only, so it needs no reset.
    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_a[wr_ptr]   <= in_a;
            mem_b[wr_ptr]   <= in_b;
            mem_acc[wr_ptr] <= in_acc;
            mem_clr[wr_ptr] <= in_clr;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Issue stage: these registers drive the adder inputs directly.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            iss_vld <= 1'b0;
            adder_a <= '0;
            adder_b <= '0;
        end else if (load) begin
            iss_vld <= 1'b1;
            adder_a <= head_a;
            adder_b <= next_b;
        end else if (capture) begin
            iss_vld <= 1'b0;
        end
    end

    // Result stage: this stage captures the adder sum and holds it until downstream takes it.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            acc       <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_sum   <= adder_sum;
            acc       <= adder_sum;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Count delivered results. The counter wraps freely.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            op_count <= '0;
        end else if (out_valid && out_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

`ifdef ADDER_STREAM_CHECK_EN
    logic [WIDTH-1:0] sum_ref;

    // Reference sum. It is computed from the same registers the adder sees.
    always_comb begin
        sum_ref = adder_a + adder_b;
    end

    // Sticky error flag. It is set if the adder output disagrees with the reference at capture.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            chk_err <= 1'b0;
        end else if (capture && (adder_sum != sum_ref)) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_adder_stream_sequencer.sv
// tb_adder_stream_sequencer
// Directed testbench for adder_stream_sequencer. The bench plays the role of
// the combinational adder. With ADDER_STREAM_CHECK_EN defined, the bench can
// also force the adder output to zero to provoke chk_err.
`timescale 1ns/1ps

module tb_adder_stream_sequencer;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_acc;
    logic        in_clr;
    logic [7:0]  adder_a;
    logic [7:0]  adder_b;
    logic [7:0]  adder_sum;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_sum;
    logic [2:0]  fifo_level;
    logic [15:0] op_count;
    logic        force_zero;
`ifdef ADDER_STREAM_CHECK_EN
    logic        chk_err;
`endif

    int total;
    int bad;

    adder_stream_sequencer #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_acc     (in_acc),
        .in_clr     (in_clr),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_sum  (adder_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .fifo_level (fifo_level),
`ifdef ADDER_STREAM_CHECK_EN
        .chk_err    (chk_err),
`endif
        .op_count   (op_count)
    );

    // Stand-in for the combinational prefix adder
    assign adder_sum = force_zero ? 8'h00 : 8'(adder_a + adder_b);

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        wb_rst_i = 1'b1;
        step();
        step();
        wb_rst_i = 1'b0;
        step();
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b,
                           input logic acc, input logic clr, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
        in_clr   = clr;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output logic [7:0] sum, output bit ok);
        ok  = 1'b0;
        sum = 8'h00;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (out_valid && out_ready) begin
                sum = out_sum;
                ok  = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%0b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%0b exp=1", in_ready); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("[TB] FAIL reset_fifo_level got=%0d exp=0", fifo_level); end
        total++; if (op_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_op_count got=%0d exp=0", op_count); end
        total++; if (out_sum !== 8'h00) begin bad++; $display("[TB] FAIL reset_out_sum got=%h exp=00", out_sum); end
        total++; if (adder_a !== 8'h00 || adder_b !== 8'h00) begin bad++; $display("[TB] FAIL reset_adder_in got=%h/%h exp=00/00", adder_a, adder_b); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'h3C;
        in_b      = 8'h47;
        in_acc    = 1'b0;
        in_clr    = 1'b0;
        step();
        in_valid = 1'b0;
        total++; if (fifo_level !== 3'd1) begin bad++; $display("[TB] FAIL single_level_e0 got=%0d exp=1", fifo_level); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_e0 got=%0b exp=0", out_valid); end
        step();
        total++; if (adder_a !== 8'h3C || adder_b !== 8'h47) begin bad++; $display("[TB] FAIL single_issue got=%h/%h exp=3c/47", adder_a, adder_b); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_e1 got=%0b exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid_e2 got=%0b exp=1", out_valid); end
        total++; if (out_sum !== 8'h83) begin bad++; $display("[TB] FAIL single_sum got=%h exp=83", out_sum); end
        step();
        total++; if (op_count !== 16'd1) begin bad++; $display("[TB] FAIL single_op_count got=%0d exp=1", op_count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_e3 got=%0b exp=0", out_valid); end
    endtask

    task automatic test_wrap();
        bit         ok_p;
        bit         ok_r;
        logic [7:0] s;
        out_ready = 1'b1;
        push_op(8'hFF, 8'h01, 1'b0, 1'b0, ok_p);
        wait_result(s, ok_r);
        total++; if (!ok_p || !ok_r || s !== 8'h00) begin bad++; $display("[TB] FAIL wrap_ff_01 got=%h ok=%0b%0b exp=00", s, ok_p, ok_r); end
        push_op(8'h80, 8'h80, 1'b0, 1'b0, ok_p);
        wait_result(s, ok_r);
        total++; if (!ok_p || !ok_r || s !== 8'h00) begin bad++; $display("[TB] FAIL wrap_80_80 got=%h ok=%0b%0b exp=00", s, ok_p, ok_r); end
        step();
        total++; if (op_count !== 16'd3) begin bad++; $display("[TB] FAIL wrap_op_count got=%0d exp=3", op_count); end
    endtask

    task automatic test_acc_chain();
        logic       v [6];
        logic [7:0] s [6];
        logic [7:0] b [6];
        logic       exp_v [6];
        exp_v = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 8'h05;
        in_b      = 8'hEE;
        in_acc    = 1'b1;
        in_clr    = 1'b1;
        step();
        in_a   = 8'h07;
        in_b   = 8'h99;
        in_clr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) in_a = 8'hFA;
            if (i == 1) in_valid = 1'b0;
            v[i] = out_valid;
            s[i] = out_sum;
            b[i] = adder_b;
        end
        for (int i = 0; i < 6; i++) begin
            total++; if (v[i] !== exp_v[i]) begin bad++; $display("[TB] FAIL acc_valid_cycle%0d got=%0b exp=%0b", i, v[i], exp_v[i]); end
        end
        total++; if (s[1] !== 8'h05) begin bad++; $display("[TB] FAIL acc_sum0 got=%h exp=05", s[1]); end
        total++; if (s[3] !== 8'h0C) begin bad++; $display("[TB] FAIL acc_sum1 got=%h exp=0c", s[3]); end
        total++; if (s[5] !== 8'h06) begin bad++; $display("[TB] FAIL acc_sum2 got=%h exp=06", s[5]); end
        total++; if (b[0] !== 8'h00) begin bad++; $display("[TB] FAIL acc_clr_b got=%h exp=00", b[0]); end
        total++; if (b[2] !== 8'h05) begin bad++; $display("[TB] FAIL acc_b1 got=%h exp=05", b[2]); end
        total++; if (b[4] !== 8'h0C) begin bad++; $display("[TB] FAIL acc_b2 got=%h exp=0c", b[4]); end
        in_acc = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        int         k;
        logic       rdy;
        bit         ok;
        logic [7:0] s;
        do_reset();
        out_ready = 1'b0;
        in_acc    = 1'b0;
        in_clr    = 1'b0;
        k         = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = (k < 8);
            in_a     = 8'(8'h10 + k);
            in_b     = 8'(8'h20 + 3 * k);
            rdy      = in_ready;
            step();
            if (in_valid && rdy) k++;
        end
        in_valid = 1'b0;
        total++; if (k !== 6) begin bad++; $display("[TB] FAIL bp_accepted got=%0d exp=6", k); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready got=%0b exp=0", in_ready); end
        total++; if (fifo_level !== 3'd4) begin bad++; $display("[TB] FAIL bp_level got=%0d exp=4", fifo_level); end
        total++; if (out_valid !== 1'b1 || out_sum !== 8'h30) begin bad++; $display("[TB] FAIL bp_held got=%0b/%h exp=1/30", out_valid, out_sum); end
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            wait_result(s, ok);
            total++; if (!ok || s !== 8'(8'h30 + 4 * j)) begin bad++; $display("[TB] FAIL bp_result%0d got=%h ok=%0b exp=%h", j, s, ok, 8'(8'h30 + 4 * j)); end
        end
        total++; if (op_count !== 16'd6) begin bad++; $display("[TB] FAIL bp_op_count got=%0d exp=6", op_count); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("[TB] FAIL bp_level_end got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_reset_mid();
        int   k;
        int   stale;
        logic rdy;
        do_reset();
        out_ready = 1'b0;
        k         = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (k < 5);
            in_a     = 8'(8'h41 + k);
            in_b     = 8'h02;
            rdy      = in_ready;
            step();
            if (in_valid && rdy) k++;
        end
        in_valid = 1'b0;
        total++; if (fifo_level !== 3'd3 || out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_pre got=%0d/%0b exp=3/1", fifo_level, out_valid); end
        #2;
        wb_rst_i = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_valid got=%0b exp=0", out_valid); end
        total++; if (fifo_level !== 3'd0) begin bad++; $display("[TB] FAIL rst_mid_level got=%0d exp=0", fifo_level); end
        total++; if (op_count !== 16'd0) begin bad++; $display("[TB] FAIL rst_mid_op_count got=%0d exp=0", op_count); end
        step();
        wb_rst_i  = 1'b0;
        out_ready = 1'b1;
        stale     = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) stale++;
        end
        total++; if (stale !== 0) begin bad++; $display("[TB] FAIL rst_mid_stale got=%0d exp=0", stale); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_in_ready got=%0b exp=1", in_ready); end
    endtask

`ifdef ADDER_STREAM_CHECK_EN
    task automatic test_check();
        bit         ok_p;
        bit         ok_r;
        logic [7:0] s;
        do_reset();
        out_ready = 1'b1;
        total++; if (chk_err !== 1'b0) begin bad++; $display("[TB] FAIL chk_reset got=%0b exp=0", chk_err); end
        force_zero = 1'b1;
        push_op(8'h01, 8'h01, 1'b0, 1'b0, ok_p);
        wait_result(s, ok_r);
        force_zero = 1'b0;
        total++; if (chk_err !== 1'b1) begin bad++; $display("[TB] FAIL chk_set got=%0b exp=1", chk_err); end
        push_op(8'h02, 8'h03, 1'b0, 1'b0, ok_p);
        wait_result(s, ok_r);
        total++; if (!ok_r || s !== 8'h05) begin bad++; $display("[TB] FAIL chk_good_sum got=%h exp=05", s); end
        total++; if (chk_err !== 1'b1) begin bad++; $display("[TB] FAIL chk_sticky got=%0b exp=1", chk_err); end
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        force_zero = 1'b0;
        wb_rst_i   = 1'b0;
        in_valid   = 1'b0;
        in_a       = 8'h00;
        in_b       = 8'h00;
        in_acc     = 1'b0;
        in_clr     = 1'b0;
        out_ready  = 1'b1;
        test_reset();
        test_single();
        test_wrap();
        test_acc_chain();
        test_backpressure();
        test_reset_mid();
`ifdef ADDER_STREAM_CHECK_EN
        test_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
